// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes and apply the sign correction in the FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q;
  logic [WIDTH-1:0] acc_q, q_q, m_q, hi_q, lo_q;
  logic [CW-1:0] cnt_q;
  logic neg_q, rneg_q, bz_q, done_q, div0_q;
  logic [WIDTH-1:0] ma, mb, acc_d, q_d, quo, rem;
  logic [WIDTH:0] sum, sh, diff;
  logic [2*WIDTH-1:0] prod;
  logic accept, last;
  always_comb begin
    accept = state_q == IDLE && start;
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q == IDLE ? (start ? CALC : IDLE) : state_q == CALC ? (last ? FIX : CALC) : IDLE;
    ma = op[0] && a[WIDTH-1] ? -a : a;
    mb = op[0] && b[WIDTH-1] ? -b : b;
    sum = {1'b0, acc_q} + {1'b0, m_q};
    sh = {acc_q, q_q[WIDTH-1]};
    diff = sh - {1'b0, m_q};
    // divide: restoring subtract of m from the shifted remainder; multiply: shift-add right
    acc_d = op_q[1] ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0])
                    : (q_q[0] ? sum[WIDTH:1] : {1'b0, acc_q[WIDTH-1:1]});
    q_d = op_q[1] ? {q_q[WIDTH-2:0], ~diff[WIDTH]} : {q_q[0] ? sum[0] : acc_q[0], q_q[WIDTH-1:1]};
    prod = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
    quo = bz_q ? '1 : neg_q ? -q_q : q_q;
    rem = rneg_q ? -acc_q : acc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == FIX;
      cnt_q <= state_q == CALC ? cnt_q + CW'(1) : '0;
      if (accept) begin
        op_q <= op;
        acc_q <= '0;
        q_q <= op[1] ? ma : mb;
        m_q <= op[1] ? mb : ma;
        neg_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_q <= op[0] & a[WIDTH-1];
        bz_q <= b == '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_d;
        q_q <= q_d;
      end
      if (state_q == IDLE && hi_we) hi_q <= wdata;
      if (state_q == IDLE && lo_we) lo_q <= wdata;
      if (state_q == FIX) begin
        hi_q <= op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
        lo_q <= op_q[1] ? quo : prod[WIDTH-1:0];
        div0_q <= op_q[1] & bz_q;
      end
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, corner sequences and random ops against an arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;
  logic clk = 0, reset = 1, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic busy, done, div0;
  logic [W-1:0] hi, lo;
  int tests = 0, fails = 0;
  typedef struct {
    logic [1:0] op;
    logic [W-1:0] a, b, hi, lo;
    logic d0;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic d);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    d = 0;
    if (!o[1]) begin
      if (o[0]) p = sx * sy;
      else p = ux * uy;
      h = p[63:32];
      l = p[31:0];
    end else if (y == 0) begin
      l = '1;
      h = x;
      d = 1;
    end else if (o[0]) begin
      q = sx / sy;
      r = sx % sy;
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h80000000;
      3: return W'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction
  // Issues start in the current cycle; returns in the done cycle so a following call is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                        input bit inject, input string nm);
    logic [W-1:0] ph, pl, wd;
    logic wh, wl;
    bit bad;
    op = o; a = x; b = y; start = 1;
    wh = hi_we; wl = lo_we; wd = wdata;
    @(posedge clk); #1;
    start = 0; hi_we = 0; lo_we = 0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    if (wh) chk({nm, "_hi_write"}, 64'(hi), 64'(wd));
    if (wl) chk({nm, "_lo_write"}, 64'(lo), 64'(wd));
    ph = hi; pl = lo; bad = 0;
    for (int c = 1; c <= W + 1; c++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== ph || lo !== pl) bad = 1;
      if (inject && c == 10) begin
        start = 1; op = 2'b10; a = 5; b = 3; hi_we = 1; wdata = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      start = 0; hi_we = 0;
    end
    chk({nm, "_busy_window"}, 64'(bad), 64'(0));
    chk({nm, "_done"}, 64'(done), 64'(1));
    chk({nm, "_busy_off"}, 64'(busy), 64'(0));
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    chk({nm, "_div0"}, 64'(div0), 64'(ed));
  endtask
  initial begin
    logic [W-1:0] eh, el, x, y;
    logic ed;
    logic [1:0] o;
    bit seen;
    tbl[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tbl[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3] = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    tbl[4] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    tbl[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    reset = 1;
    start = 1; hi_we = 1; lo_we = 1; wdata = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    start = 0; hi_we = 0; lo_we = 0;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_div0", 64'(div0), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    reset = 0;
    for (int i = 0; i < 6; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].d0, 0, $sformatf("vec%0d", i));
    @(posedge clk); #1;
    chk("done_single_pulse", 64'(done), 64'(0));
    hi_we = 1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    hi_we = 0;
    chk("mthi", 64'(hi), 64'hA5A5A5A5);
    lo_we = 1; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    lo_we = 0;
    chk("mtlo", 64'(lo), 64'h5A5A5A5A);
    chk("mthi_kept", 64'(hi), 64'hA5A5A5A5);
    lo_we = 1; wdata = 32'h11111111;
    run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, "start_with_mtlo");
    model(2'b00, 32'h12345678, 32'h9ABCDEF0, eh, el, ed);
    run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, eh, el, ed, 1, "busy_ignore");
    repeat (40) begin
      o = 2'($urandom); x = pick(); y = pick();
      model(o, x, y, eh, el, ed);
      run_op(o, x, y, eh, el, ed, 0, $sformatf("rnd_op%0d_%h_%h", o, x, y));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    hi_we = 1; lo_we = 1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 0;
    op = 2'b00; a = '1; b = '1; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    seen = 0;
    repeat (40) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(seen), 64'(0));
    chk("abort_idle_hi", 64'(hi), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
